// File: rtl/proj_pkg.sv
// Shared FM sizes and fragment types for the seed-extension datapath.
// Reads the FM buffer with FM_READ_LATENCY, fragment is FRAG_LEN bases of FM_DATA_BITS each.
package proj_pkg;

   localparam int FRAG_LEN          = 8;
   localparam int FM_DATA_BITS      = 2;
   localparam int INDICE_LEN        = 5;
   localparam int SIGNED_INDICE_LEN = 6;
   localparam int FM_BUFFER_COUNT   = 2;
   localparam int FM_BUFFER_SIZE    = 1 << INDICE_LEN;
   localparam int FM_READ_LATENCY   = 1;

   localparam int FM_EXTENDER_FRAG_LEN_BITS = FRAG_LEN * FM_DATA_BITS;

   typedef logic [FM_EXTENDER_FRAG_LEN_BITS-1:0] frag_t;
   typedef logic [FRAG_LEN-1:0]                  frag_mask_t;

   // p is a widened signed position; it lies in 0..FM_BUFFER_SIZE-1 exactly when
   // the sign bit and every bit at or above INDICE_LEN are clear.
   function automatic logic fm_pos_in_range(input logic [SIGNED_INDICE_LEN:0] p);
      return p[SIGNED_INDICE_LEN:INDICE_LEN] == '0;
   endfunction

endpackage

// File: rtl/fm_frag_reader.sv
// Gathers FRAG_LEN bases from one FM buffer into a masked fragment; response 10 cycles after acceptance.
// One request in flight: req_ready only in IDLE, fragment held stable until resp_ready.
module fm_frag_reader
   import proj_pkg::*;
(
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                req_valid,
   output logic                                req_ready,
   input  logic signed [SIGNED_INDICE_LEN-1:0] req_start,
   input  logic                                req_buf,
   output logic                                mem_rd_en,
   output logic                                mem_rd_buf,
   output logic        [INDICE_LEN-1:0]        mem_rd_addr,
   input  logic        [FM_DATA_BITS-1:0]      mem_rd_data,
   output logic                                resp_valid,
   input  logic                                resp_ready,
   output frag_t                               resp_frag,
   output frag_mask_t                          resp_mask
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_READ = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   localparam int CNT_BITS = $clog2(FRAG_LEN + 1);
   localparam int IDX_BITS = $clog2(FRAG_LEN);

   logic [1:0]                   state;
   logic [CNT_BITS-1:0]          base_cnt;
   logic [SIGNED_INDICE_LEN-1:0] start_q;
   logic                         buf_q;
   logic [SIGNED_INDICE_LEN:0]   pos;
   logic                         pos_ok;
   logic                         cap_vld;
   logic                         cap_hit;
   logic [IDX_BITS-1:0]          cap_idx;
   frag_t                        frag_q;
   frag_mask_t                   mask_q;

   // Sign-extend the start by one bit so start+7 can never wrap into range.
   assign pos    = {start_q[SIGNED_INDICE_LEN-1], start_q}
                 + {{(SIGNED_INDICE_LEN + 1 - CNT_BITS){1'b0}}, base_cnt};
   assign pos_ok = fm_pos_in_range(pos);

   assign req_ready   = (state == ST_IDLE) && !rst;
   assign resp_valid  = (state == ST_RESP) && !rst;
   assign mem_rd_en   = (state == ST_READ) && pos_ok && !rst;
   assign mem_rd_addr = mem_rd_en ? pos[INDICE_LEN-1:0] : '0;
   assign mem_rd_buf  = mem_rd_en ? buf_q : 1'b0;
   assign resp_frag   = rst ? '0 : frag_q;
   assign resp_mask   = rst ? '0 : mask_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         base_cnt <= '0;
         start_q  <= '0;
         buf_q    <= 1'b0;
         cap_vld  <= 1'b0;
         cap_hit  <= 1'b0;
         cap_idx  <= '0;
         frag_q   <= '0;
         mask_q   <= '0;
      end else begin
         // Every READ cycle yields a capture slot next cycle, in range or not.
         cap_vld <= (state == ST_READ);
         cap_hit <= pos_ok;
         cap_idx <= base_cnt[IDX_BITS-1:0];

         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  state    <= ST_READ;
                  start_q  <= req_start;
                  buf_q    <= req_buf;
                  base_cnt <= '0;
                  frag_q   <= '0;
                  mask_q   <= '0;
               end
            end
            ST_READ: begin
               base_cnt <= base_cnt + 1'b1;
               if (base_cnt == CNT_BITS'(FRAG_LEN - 1)) state <= ST_WAIT;
            end
            ST_WAIT: state <= ST_RESP;
            ST_RESP: if (resp_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase

         if (cap_vld) begin
            frag_q[FM_DATA_BITS*cap_idx +: FM_DATA_BITS] <= cap_hit ? mem_rd_data : '0;
            mask_q[cap_idx]                              <= cap_hit;
         end
      end
   end

endmodule

// File: tb/tb_fm_frag_reader.sv
// Directed bench for fm_frag_reader: FM memory model, cycle-level reference model, literal checks.
module tb_fm_frag_reader;
   import proj_pkg::*;

   logic                                clk = 1'b0;
   logic                                rst;
   logic                                req_valid;
   logic                                req_ready;
   logic signed [SIGNED_INDICE_LEN-1:0] req_start;
   logic                                req_buf;
   logic                                mem_rd_en;
   logic                                mem_rd_buf;
   logic        [INDICE_LEN-1:0]        mem_rd_addr;
   logic        [FM_DATA_BITS-1:0]      mem_rd_data;
   logic                                resp_valid;
   logic                                resp_ready;
   frag_t                               resp_frag;
   frag_mask_t                          resp_mask;

   fm_frag_reader dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_start   (req_start),
      .req_buf     (req_buf),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_buf  (mem_rd_buf),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_frag   (resp_frag),
      .resp_mask   (resp_mask)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // FM storage: buf0 base k = k mod 4, buf1 base k = 3 - (k mod 4); junk returned when not read.
   logic [1:0] mem [0:1][0:31];
   always @(posedge clk)
      mem_rd_data <= mem_rd_en ? mem[mem_rd_buf][mem_rd_addr] : 2'($urandom_range(3));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Reference model: request timeline and expected fragment from plain arithmetic.
   bit          m_busy     = 1'b0;
   bit          m_post_rst = 1'b0;
   int          m_t, m_start, m_buf;
   logic [15:0] m_frag;
   logic [7:0]  m_mask;
   int          mk, mp, e_addr, e_buf;
   bit          e_rdy, e_en, e_vld;

   int          acc_q[$];
   int          resp_cyc_q[$];
   logic [15:0] resp_frag_q[$];
   logic [7:0]  resp_mask_q[$];

   always @(negedge clk) begin
      e_rdy  = !rst && !m_busy;
      e_en   = 1'b0;
      e_addr = 0;
      e_buf  = 0;
      if (!rst && m_busy) begin
         mk = cyc - m_t - 1;
         if (mk >= 0 && mk < FRAG_LEN) begin
            mp = m_start + mk;
            if (mp >= 0 && mp < FM_BUFFER_SIZE) begin
               e_en   = 1'b1;
               e_addr = mp;
               e_buf  = m_buf;
            end
         end
      end
      e_vld = !rst && m_busy && (cyc >= m_t + 10);

      chk("req_ready",   req_ready,   e_rdy);
      chk("mem_rd_en",   mem_rd_en,   e_en);
      chk("mem_rd_addr", mem_rd_addr, e_addr);
      chk("mem_rd_buf",  mem_rd_buf,  e_buf);
      chk("resp_valid",  resp_valid,  e_vld);
      if (e_vld) begin
         chk("resp_frag", resp_frag, m_frag);
         chk("resp_mask", resp_mask, m_mask);
      end
      if (rst || m_post_rst) begin
         chk("rst_frag_zero", resp_frag, 0);
         chk("rst_mask_zero", resp_mask, 0);
      end

      m_post_rst = rst;
      if (rst) begin
         m_busy = 1'b0;
      end else if (e_vld && resp_ready) begin
         m_busy = 1'b0;
         resp_cyc_q.push_back(cyc);
         resp_frag_q.push_back(resp_frag);
         resp_mask_q.push_back(resp_mask);
      end else if (req_valid && e_rdy) begin
         m_busy  = 1'b1;
         m_t     = cyc;
         m_start = req_start;
         m_buf   = int'(req_buf);
         m_frag  = '0;
         m_mask  = '0;
         for (int i = 0; i < FRAG_LEN; i++) begin
            mp = m_start + i;
            if (mp >= 0 && mp < FM_BUFFER_SIZE) begin
               m_mask[i]       = 1'b1;
               m_frag[2*i +: 2] = mem[m_buf][mp];
            end
         end
         acc_q.push_back(cyc);
      end
   end

   task automatic send(input int start, input int b);
      int n = 0;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_start = 6'(start);
      req_buf   = b[0];
      @(negedge clk);
      while (!req_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("accept_in_time", req_ready, 1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic expect_resp(input string name, input logic [15:0] ef, input logic [7:0] em,
                              input int lat, output int acc);
      int n = 0;
      int rc;
      acc = 0;
      while (resp_cyc_q.size() == 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (resp_cyc_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: no response within bound", name);
      end else begin
         rc  = resp_cyc_q.pop_front();
         acc = acc_q.pop_front();
         chk({name, "_frag"}, resp_frag_q.pop_front(), ef);
         chk({name, "_mask"}, resp_mask_q.pop_front(), em);
         chk({name, "_latency"}, rc - acc, lat);
      end
   endtask

   int a1, a2;

   initial begin
      for (int k = 0; k < 32; k++) begin
         mem[0][k] = 2'(k % 4);
         mem[1][k] = 2'(3 - (k % 4));
      end
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_start  = '0;
      req_buf    = 1'b0;
      resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      send(4, 0);
      expect_resp("start4", 16'hE4E4, 8'hFF, 10, a1);
      send(-3, 0);
      expect_resp("start_m3", 16'h3900, 8'hF8, 10, a1);
      send(28, 0);
      expect_resp("start28", 16'h00E4, 8'h0F, 10, a1);

      // Backpressure: consumer stalls 5 cycles while a competing request is offered.
      resp_ready = 1'b0;
      send(0, 0);
      begin
         int n = 0;
         while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
         end
      end
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_start = 6'd10;
      req_buf   = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      expect_resp("stall", 16'hE4E4, 8'hFF, 15, a1);

      // Reset in the middle of a fragment read.
      send(4, 0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      acc_q.delete();
      send(0, 0);
      expect_resp("after_rst", 16'hE4E4, 8'hFF, 10, a1);

      // Back-to-back requests on different buffers.
      send(0, 0);
      send(0, 1);
      expect_resp("b2b_first", 16'hE4E4, 8'hFF, 10, a1);
      expect_resp("b2b_second", 16'h1B1B, 8'hFF, 10, a2);
      chk("b2b_gap", a2 - a1, 11);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      n_fail++;
      $display("FAIL global_timeout: got running expected finished");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
